peak_interval_tracker: RTL

Downstream consumer of the peak detector's `peak_detected` strobe. It measures the spacing in samples between consecutive peaks, keeps a running average over the last 2^DEPTH_LOG2 accepted intervals, and flags loss of signal when no peak arrives within a timeout. Its outputs feed rate computation and host status logic.

---
 rtl/peak_interval_tracker.sv | 139 +++++++++++++
 1 files changed

// File: rtl/peak_interval_tracker.sv
// peak_interval_tracker: measures sample spacing between consecutive accepted
// peaks, keeps a running average over the last 2^DEPTH_LOG2 intervals, and
// flags loss of signal when no peak arrives within TIMEOUT samples.
// Optional macro PEAK_INTERVAL_REJECT_EN enables outlier rejection against
// the running average (window avg +/- avg/4, only while the ring is full).
module peak_interval_tracker #(
    parameter int DEPTH_LOG2   = 3,
    parameter int CNT_W        = 16,
    parameter int MIN_INTERVAL = 50,
    parameter int TIMEOUT      = 2000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic             peak_in,
    output logic [CNT_W-1:0] interval_out,
    output logic             interval_valid,
    output logic             interval_reject,
    output logic [CNT_W-1:0] avg_interval,
    output logic             avg_valid,
    output logic             signal_lost
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SUM_W = CNT_W + DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, TRACK, LOST} state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_inc;
    logic [CNT_W:0]        interval;
    logic                  long_enough;
    logic                  timeout_hit;
    logic                  in_window;
    logic [CNT_W-1:0]      ring [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   fill;
    logic [SUM_W-1:0]      sum;

    // Interval is one more than the count since the reference sample; the
    // extra bit keeps the saturated count from wrapping in the compares.
    assign cnt_inc     = (cnt == '1) ? cnt : cnt + 1'b1;
    assign interval    = {1'b0, cnt} + (CNT_W+1)'(1);
    assign long_enough = (interval >= (CNT_W+1)'(MIN_INTERVAL));
    assign timeout_hit = (interval >= (CNT_W+1)'(TIMEOUT));

    assign avg_interval = sum[SUM_W-1:DEPTH_LOG2];
    assign avg_valid    = (fill == (DEPTH_LOG2+1)'(DEPTH));

`ifdef PEAK_INTERVAL_REJECT_EN
    logic [CNT_W-1:0] margin;
    logic [CNT_W:0]   win_lo;
    logic [CNT_W:0]   win_hi;

    // Acceptance window around the current average; open until the ring is full.
    always_comb begin
        margin    = avg_interval >> 2;
        win_lo    = {1'b0, avg_interval} - {1'b0, margin};
        win_hi    = {1'b0, avg_interval} + {1'b0, margin};
        in_window = !avg_valid || ((interval >= win_lo) && (interval <= win_hi));
    end
`else
    assign in_window = 1'b1;
`endif

    // Tracker FSM, interval register and one-stage averaging pipeline.
    // The averaging stage consumes the interval register the cycle after it
    // is written; a timeout clear is placed after it so the clear dominates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            interval_out    <= '0;
            interval_valid  <= 1'b0;
            interval_reject <= 1'b0;
            signal_lost     <= 1'b0;
            wr_ptr          <= '0;
            fill            <= '0;
            sum             <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) ring[i] <= '0;
        end else begin
            interval_valid  <= 1'b0;
            interval_reject <= 1'b0;

            if (interval_valid) begin
                ring[wr_ptr] <= interval_out;
                sum          <= sum - SUM_W'(ring[wr_ptr]) + SUM_W'(interval_out);
                wr_ptr       <= wr_ptr + 1'b1;
                if (!avg_valid) fill <= fill + 1'b1;
            end

            if (sample_valid) begin
                case (state)
                    IDLE: begin
                        if (peak_in) begin
                            state <= TRACK;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    TRACK: begin
                        if (peak_in && long_enough) begin
                            cnt <= '0;
                            if (in_window) begin
                                interval_out   <= interval[CNT_W-1:0];
                                interval_valid <= 1'b1;
                            end else begin
                                interval_reject <= 1'b1;
                            end
                        end else if (timeout_hit) begin
                            state       <= LOST;
                            signal_lost <= 1'b1;
                            cnt         <= cnt_inc;
                            sum         <= '0;
                            fill        <= '0;
                            wr_ptr      <= '0;
                            for (int unsigned i = 0; i < DEPTH; i++) ring[i] <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    LOST: begin
                        if (peak_in) begin
                            state       <= TRACK;
                            signal_lost <= 1'b0;
                            cnt         <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
